dmem_wbuf: RTL and testbench

Data memory with a posted write buffer. It sits directly downstream of the rf-as-memory processor core and consumes its `mem_w_*` store port and `mem_r_*` load port. Stores go into a small FIFO and drain to a slow-write backing array. Loads are answered combinationally from the array. When store-to-load forwarding is built in, loads are answered from the youngest buffered store to the same address instead.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/wbuf_fifo.sv | 73 +++++++
 rtl/dmem_wbuf.sv | 107 ++++++++++
 tb/tb_dmem_wbuf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the posted-write data memory: default widths, buffer entry, drain writer state.
package dmem_pkg;

  localparam int DMEM_AW = 8;
  localparam int DMEM_DW = 8;

  typedef struct packed {
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] data;
  } wbuf_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wr_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store FIFO: entry storage, head/tail/count, and youngest-match lookup for loads.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int  AW      = DMEM_AW,
  parameter int  DW      = DMEM_DW,
  parameter int  DEPTH   = 4,
  parameter type entry_t = wbuf_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  entry_t                     i_push_entry,
  input  logic                       i_pop,
  output entry_t                     o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic [AW-1:0]              i_lk_addr,
  output logic                       o_hit,
  output logic [$clog2(DEPTH)-1:0]   o_hit_idx,
  output logic [DW-1:0]              o_hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t            r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [DEPTH-1:0]  w_match;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PW'(1);
      if (i_pop)  r_head <= r_head + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_push_entry;
  end

  // Bit k refers to the entry k places behind the head, so higher k is younger.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_match[k] = (CW'(k) < r_count) && (r_mem[r_head + PW'(k)].addr == i_lk_addr);
    end
  end

  always_comb begin
    o_hit_idx  = '0;
    o_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_hit_idx  = w_match[k] ? (r_head + PW'(k)) : o_hit_idx;
      o_hit_data = w_match[k] ? r_mem[r_head + PW'(k)].data : o_hit_data;
    end
  end

  assign o_hit   = |w_match;
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/dmem_wbuf.sv
// Data memory with posted write buffer and slow-write drain; define DMEM_FWD_EN to forward
// buffered stores to loads, otherwise loads to a buffered address stall until it commits.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int AW     = DMEM_AW,
  parameter int DW     = DMEM_DW,
  parameter int DEPTH  = 4,
  parameter int WR_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_w_en,
  input  logic [AW-1:0]            mem_w_addr,
  input  logic [DW-1:0]            mem_w_data,
  output logic                     mem_w_ready,
  input  logic                     mem_r_en,
  input  logic [AW-1:0]            mem_r_addr,
  output logic [DW-1:0]            mem_r_data,
  output logic                     mem_r_ready,
  output logic [$clog2(DEPTH):0]   wbuf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic [DW-1:0]  r_array [2**AW];
  wr_state_t      r_state;
  logic [LW-1:0]  r_lat_cnt;

  entry_t         w_head;
  logic [CW-1:0]  w_count;
  logic           w_push;
  logic           w_commit;
  logic           w_hit;
  logic [PW-1:0]  w_hit_idx;
  logic [DW-1:0]  w_hit_data;
  logic           w_unused;

  assign mem_w_ready = (w_count < CW'(DEPTH));
  assign w_push      = mem_w_en && mem_w_ready;
  // Gated by rst so an edge with reset asserted never commits the head.
  assign w_commit    = rst && (r_state == BUSY) && (r_lat_cnt == LW'(0));
  assign wbuf_count  = w_count;

  wbuf_fifo #(
    .AW      (AW),
    .DW      (DW),
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (entry_t'({mem_w_addr, mem_w_data})),
    .i_pop        (w_commit),
    .o_head       (w_head),
    .o_count      (w_count),
    .i_lk_addr    (mem_r_addr),
    .o_hit        (w_hit),
    .o_hit_idx    (w_hit_idx),
    .o_hit_data   (w_hit_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_count != CW'(0)) begin
            r_state   <= BUSY;
            r_lat_cnt <= LW'(WR_LAT - 1);
          end
        end
        BUSY: begin
          if (r_lat_cnt != LW'(0)) r_lat_cnt <= r_lat_cnt - LW'(1);
          else                     r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Backing array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_commit) r_array[w_head.addr] <= w_head.data;
  end

`ifdef DMEM_FWD_EN
  assign mem_r_data  = w_hit ? w_hit_data : r_array[mem_r_addr];
  assign mem_r_ready = 1'b1;
`else
  assign mem_r_data  = r_array[mem_r_addr];
  assign mem_r_ready = !(mem_r_en && w_hit);
`endif

  assign w_unused = ^{w_hit_idx, w_hit_data, mem_r_en};

endmodule

// File: tb/tb_dmem_wbuf.sv
// Scoreboard bench for dmem_wbuf; expectations adapt to whether DMEM_FWD_EN is defined.
module tb_dmem_wbuf;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_w_en;
  logic [7:0] mem_w_addr;
  logic [7:0] mem_w_data;
  logic       mem_w_ready;
  logic       mem_r_en;
  logic [7:0] mem_r_addr;
  logic [7:0] mem_r_data;
  logic       mem_r_ready;
  logic [2:0] wbuf_count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] shadow [256];
  logic [7:0] exp_q [$];

  dmem_wbuf #(.AW(8), .DW(8), .DEPTH(4), .WR_LAT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_w_en    (mem_w_en),
    .mem_w_addr  (mem_w_addr),
    .mem_w_data  (mem_w_data),
    .mem_w_ready (mem_w_ready),
    .mem_r_en    (mem_r_en),
    .mem_r_addr  (mem_r_addr),
    .mem_r_data  (mem_r_data),
    .mem_r_ready (mem_r_ready),
    .wbuf_count  (wbuf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    int n;
    mem_w_en = 1'b1; mem_w_addr = a; mem_w_data = d;
    @(negedge clk);
    n = 0;
    while (!mem_w_ready && n < 40) begin @(negedge clk); n++; end
    chk("st_rdy", 32'(mem_w_ready), 32'd1);
    shadow[a] = d;
    @(posedge clk); #1;
    mem_w_en = 1'b0;
  endtask

  task automatic load_check(input logic [7:0] a, input string tag);
    int n;
    exp_q.push_back(shadow[a]);
    mem_r_en = 1'b1; mem_r_addr = a;
    @(negedge clk);
    n = 0;
    while (!mem_r_ready && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, 32'(mem_r_ready), 32'd1);
    chk(tag, 32'(mem_r_data), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    mem_r_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (wbuf_count != 3'd0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", 32'(wbuf_count), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, acc_c, c;
    rst = 1'b0; mem_w_en = 1'b0; mem_w_addr = 8'h00; mem_w_data = 8'h00;
    mem_r_en = 1'b0; mem_r_addr = 8'h00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cnt",  32'(wbuf_count),  32'd0);
    chk("rst_wrdy", 32'(mem_w_ready), 32'd1);
    chk("rst_rrdy", 32'(mem_r_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single store then immediate load: visible next cycle, committed on edge ending cycle 4.
    mem_w_en = 1'b1; mem_w_addr = 8'h10; mem_w_data = 8'hAB;
    @(negedge clk);
    chk("t1_wrdy", 32'(mem_w_ready), 32'd1);
    @(posedge clk); #1;
    shadow[8'h10] = 8'hAB;
    mem_w_en = 1'b0;
    mem_r_en = 1'b1; mem_r_addr = 8'h10;
    exp_q.push_back(8'hAB);
    for (int cy = 1; cy <= 5; cy++) begin
      @(negedge clk);
      if (cy == 1) chk("t1_cnt1", 32'(wbuf_count), 32'd1);
`ifdef DMEM_FWD_EN
      chk("t1_rrdy", 32'(mem_r_ready), 32'd1);
      chk("t1_fwd", 32'(mem_r_data), 32'hAB);
`else
      chk("t1_rrdy", 32'(mem_r_ready), 32'(cy == 5));
`endif
      if (cy == 5) begin
        chk("t1_cnt5", 32'(wbuf_count), 32'd0);
        chk("t1_data", 32'(mem_r_data), 32'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
    end
    mem_r_en = 1'b0;

    // Five back-to-back stores: buffer full only in cycle 4, fifth accepted in cycle 5.
    k = 0; c = 0; acc_c = -1;
    while (k < 5 && c < 20) begin
      mem_w_en = 1'b1; mem_w_addr = 8'(k); mem_w_data = 8'h40 + 8'(k);
      @(negedge clk);
      chk("t2_wrdy", 32'(mem_w_ready), 32'(c != 4));
      if (mem_w_ready) begin
        shadow[k] = mem_w_data;
        if (k == 4) acc_c = c;
        k++;
      end
      @(posedge clk); #1;
      c++;
    end
    mem_w_en = 1'b0;
    chk("t2_acc5", 32'(acc_c), 32'd5);
    wait_drain();
    for (int i = 0; i < 5; i++) load_check(8'(i), "t2_rd");

    // Two stores to one address: youngest wins, array ends with the later value.
    store(8'h20, 8'h11);
    store(8'h20, 8'h22);
    load_check(8'h20, "t3_young");
    wait_drain();
    load_check(8'h20, "t3_array");

    // Reset before the first commit of a 3-entry drain drops every buffered store.
    store(8'h50, 8'h01);
    store(8'h51, 8'h02);
    store(8'h52, 8'h03);
    wait_drain();
    for (int i = 0; i < 3; i++) begin
      mem_w_en = 1'b1; mem_w_addr = 8'h50 + 8'(i); mem_w_data = 8'hE0 + 8'(i);
      @(negedge clk);
      chk("t4_wrdy", 32'(mem_w_ready), 32'd1);
      @(posedge clk); #1;
    end
    mem_w_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_cnt",  32'(wbuf_count),  32'd0);
    chk("t4_wrdy", 32'(mem_w_ready), 32'd1);
    chk("t4_rrdy", 32'(mem_r_ready), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) load_check(8'h50 + 8'(i), "t4_keep");

    // Stores spaced one per WR_LAT+1 cycles: occupancy stays at most 1 while pointers wrap.
    for (int cy = 0; cy < 44; cy++) begin
      int i;
      i = cy / 4;
      mem_w_en   = ((cy % 4) == 0) && (i < 10);
      mem_w_addr = 8'h60 + 8'(i % 3);
      mem_w_data = 8'(i * 7 + 3);
      @(negedge clk);
      chk("t6_wrdy", 32'(mem_w_ready), 32'd1);
      chk("t6_cnt_le1", 32'(wbuf_count <= 3'd1), 32'd1);
      if (mem_w_en) shadow[mem_w_addr] = mem_w_data;
      @(posedge clk); #1;
    end
    mem_w_en = 1'b0;
    @(negedge clk);
    chk("t6_cnt_end", 32'(wbuf_count), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) load_check(8'h60 + 8'(i), "t6_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
